// File: rtl/mem_stage_ctrl_pkg.sv
// Shared LC-3b types for the MEM-stage sequencer: opcodes, control word, FSM state and
// byte-enable constants.
package mem_stage_ctrl_pkg;

  typedef enum logic [3:0] {
    op_br   = 4'h0,
    op_add  = 4'h1,
    op_ldb  = 4'h2,
    op_stb  = 4'h3,
    op_jsr  = 4'h4,
    op_and  = 4'h5,
    op_ldr  = 4'h6,
    op_str  = 4'h7,
    op_rti  = 4'h8,
    op_not  = 4'h9,
    op_ldi  = 4'ha,
    op_sti  = 4'hb,
    op_jmp  = 4'hc,
    op_shf  = 4'hd,
    op_lea  = 4'he,
    op_trap = 4'hf
  } lc3b_opcode;

  typedef struct packed {
    lc3b_opcode opcode;
    logic       mem_read;
    logic       mem_write;
  } lc3b_control_word;

  typedef enum logic {IDLE, INDIRECT} mem_ctrl_state;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  function automatic logic is_byte_op(lc3b_opcode op);
    return (op == op_ldb) || (op == op_stb);
  endfunction

  function automatic logic is_indirect_op(lc3b_opcode op);
    return (op == op_ldi) || (op == op_sti);
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// MEM-stage bus: pipeline-side request/stall signals plus the data-memory port.
// master = pipeline and memory side, slave = mem_stage_ctrl.
interface mem_stage_ctrl_if;
  import mem_stage_ctrl_pkg::*;

  logic             in_valid;
  lc3b_control_word ctrl;
  logic [15:0]      addr;
  logic [15:0]      wdata;
  logic             stall;
  logic             done;
  logic [15:0]      rdata;
  logic             mem_read;
  logic             mem_write;
  logic [1:0]       mem_byte_enable;
  logic [15:0]      mem_address;
  logic [15:0]      mem_wdata;
  logic             mem_resp;
  logic [15:0]      mem_rdata;

  modport master (
    output in_valid, ctrl, addr, wdata, mem_resp, mem_rdata,
    input  stall, done, rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

  modport slave (
    input  in_valid, ctrl, addr, wdata, mem_resp, mem_rdata,
    output stall, done, rdata, mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata
  );

endinterface

// File: rtl/mem_byte_align.sv
// Combinational byte lane formatting: byte enables, replicated store data and
// zero-extended byte load data.
module mem_byte_align
  import mem_stage_ctrl_pkg::*;
(
  input  lc3b_opcode  i_opcode,
  input  logic        i_addr0,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_mem_rdata,
  output logic [1:0]  o_byte_enable,
  output logic [15:0] o_mem_wdata,
  output logic [15:0] o_rdata
);

  logic w_byte;

  always_comb begin
    w_byte        = is_byte_op(i_opcode);
    o_byte_enable = BE_WORD;
    o_mem_wdata   = i_wdata;
    o_rdata       = i_mem_rdata;
    if (w_byte) begin
      o_byte_enable = i_addr0 ? BE_HI : BE_LO;
      o_mem_wdata   = {i_wdata[7:0], i_wdata[7:0]};
      o_rdata       = {8'h00, i_addr0 ? i_mem_rdata[15:8] : i_mem_rdata[7:0]};
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// LC-3b MEM-stage sequencer: one access for loads/stores/TRAP, two for LDI/STI.
// Optional macro MEM_PERF_CNT_EN adds stall-cycle and access counters.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mem_stage_ctrl_if.slave    bus
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]        perf_stall_cycles,
  output logic [31:0]        perf_accesses
`endif
);

  mem_ctrl_state r_state;
  logic [15:0]   r_ptr;

  logic        w_mem_instr;
  logic        w_indirect;
  logic        w_byte;
  logic        w_busy;
  logic        w_read;
  logic        w_write;
  logic        w_access;
  logic        w_final;
  logic        w_done;
  logic [15:0] w_address;
  logic [1:0]  w_be;
  logic [15:0] w_al_wdata;
  logic [15:0] w_al_rdata;

  assign w_mem_instr = bus.ctrl.mem_read | bus.ctrl.mem_write | (bus.ctrl.opcode == op_sti);
  assign w_indirect  = is_indirect_op(bus.ctrl.opcode);
  assign w_byte      = is_byte_op(bus.ctrl.opcode);
  assign w_busy      = bus.in_valid & w_mem_instr;

  always_comb begin
    w_read    = 1'b0;
    w_write   = 1'b0;
    w_address = '0;
    unique case (r_state)
      IDLE: begin
        if (w_busy) begin
          // Indirect ops always start with a word pointer fetch.
          w_read    = w_indirect | bus.ctrl.mem_read;
          w_write   = ~w_indirect & bus.ctrl.mem_write;
          w_address = w_byte ? bus.addr : {bus.addr[15:1], 1'b0};
        end
      end
      INDIRECT: begin
        if (w_busy) begin
          w_read    = (bus.ctrl.opcode == op_ldi);
          w_write   = (bus.ctrl.opcode == op_sti);
          w_address = r_ptr;
        end
      end
      default: ;
    endcase
  end

  assign w_access = w_read | w_write;
  assign w_final  = (r_state == INDIRECT) | ~w_indirect;
  assign w_done   = bus.in_valid & (~w_mem_instr | (w_access & bus.mem_resp & w_final));

  mem_byte_align u_align (
    .i_opcode      (bus.ctrl.opcode),
    .i_addr0       (bus.addr[0]),
    .i_wdata       (bus.wdata),
    .i_mem_rdata   (bus.mem_rdata),
    .o_byte_enable (w_be),
    .o_mem_wdata   (w_al_wdata),
    .o_rdata       (w_al_rdata)
  );

  assign bus.stall           = w_busy & ~w_done;
  assign bus.done            = w_done;
  assign bus.rdata           = (w_done & w_mem_instr) ? w_al_rdata : '0;
  assign bus.mem_read        = w_read;
  assign bus.mem_write       = w_write;
  assign bus.mem_byte_enable = w_access ? w_be : 2'b00;
  assign bus.mem_address     = w_address;
  assign bus.mem_wdata       = w_write ? w_al_wdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_access && bus.mem_resp && w_indirect) begin
            r_ptr   <= {bus.mem_rdata[15:1], 1'b0};
            r_state <= INDIRECT;
          end
        end
        INDIRECT: begin
          if (w_access && bus.mem_resp) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_accesses     <= '0;
    end else begin
      if (bus.stall) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (w_access && bus.mem_resp) begin
        perf_accesses <= perf_accesses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: hand-computed expectations for LDR, STB, LDI, STI,
// ADD/LDB, stray responses and reset out of INDIRECT.
module tb_mem_stage_ctrl;
  import mem_stage_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_stage_ctrl_if u_if ();

`ifdef MEM_PERF_CNT_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_accesses;
`endif

  mem_stage_ctrl u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
`ifdef MEM_PERF_CNT_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_accesses     (perf_accesses)
`endif
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic lc3b_control_word cw(input lc3b_opcode op, input logic rd, input logic wr);
    lc3b_control_word c;
    c.opcode    = op;
    c.mem_read  = rd;
    c.mem_write = wr;
    return c;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input lc3b_control_word c, input logic [15:0] a,
                       input logic [15:0] wd);
    u_if.in_valid = v;
    u_if.ctrl     = c;
    u_if.addr     = a;
    u_if.wdata    = wd;
  endtask

  task automatic resp(input logic r, input logic [15:0] d);
    u_if.mem_resp  = r;
    u_if.mem_rdata = d;
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, ".stall"}, 32'(u_if.stall), 32'h0);
    check_eq({pfx, ".done"}, 32'(u_if.done), 32'h0);
    check_eq({pfx, ".rdata"}, 32'(u_if.rdata), 32'h0);
    check_eq({pfx, ".mem_read"}, 32'(u_if.mem_read), 32'h0);
    check_eq({pfx, ".mem_write"}, 32'(u_if.mem_write), 32'h0);
    check_eq({pfx, ".be"}, 32'(u_if.mem_byte_enable), 32'h0);
    check_eq({pfx, ".mem_address"}, 32'(u_if.mem_address), 32'h0);
    check_eq({pfx, ".mem_wdata"}, 32'(u_if.mem_wdata), 32'h0);
`ifdef MEM_PERF_CNT_EN
    check_eq({pfx, ".perf_stall"}, perf_stall_cycles, 32'h0);
    check_eq({pfx, ".perf_acc"}, perf_accesses, 32'h0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, cw(op_br, 1'b0, 1'b0), 16'h0000, 16'h0000);
    resp(1'b0, 16'h0000);
    #2;
    check_all_zero("reset");
    next_cycle();
    rst_n = 1'b1;

    // LDR: response three cycles after issue
    next_cycle();
    drive(1'b1, cw(op_ldr, 1'b1, 1'b0), 16'h3001, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("ldr.addr", 32'(u_if.mem_address), 32'h3000);
      check_eq("ldr.be", 32'(u_if.mem_byte_enable), 32'h3);
      check_eq("ldr.read", 32'(u_if.mem_read), 32'h1);
      check_eq("ldr.stall", 32'(u_if.stall), 32'h1);
      check_eq("ldr.done_early", 32'(u_if.done), 32'h0);
      next_cycle();
    end
    resp(1'b1, 16'hBEEF);
    #1;
    check_eq("ldr.done", 32'(u_if.done), 32'h1);
    check_eq("ldr.stall_end", 32'(u_if.stall), 32'h0);
    check_eq("ldr.rdata", 32'(u_if.rdata), 32'hBEEF);

    // STB to the high byte
    next_cycle();
    resp(1'b0, 16'h0000);
    drive(1'b1, cw(op_stb, 1'b0, 1'b1), 16'h4005, 16'h12A7);
    #1;
    check_eq("stb.write", 32'(u_if.mem_write), 32'h1);
    check_eq("stb.read", 32'(u_if.mem_read), 32'h0);
    check_eq("stb.be", 32'(u_if.mem_byte_enable), 32'h2);
    check_eq("stb.wdata", 32'(u_if.mem_wdata), 32'hA7A7);
    check_eq("stb.addr", 32'(u_if.mem_address), 32'h4005);
    check_eq("stb.stall", 32'(u_if.stall), 32'h1);
    next_cycle();
    resp(1'b1, 16'h0000);
    #1;
    check_eq("stb.write_resp", 32'(u_if.mem_write), 32'h1);
    check_eq("stb.done", 32'(u_if.done), 32'h1);

    // LDI: pointer 0x6003 -> data at 0x6002
    next_cycle();
    resp(1'b0, 16'h0000);
    drive(1'b1, cw(op_ldi, 1'b1, 1'b0), 16'h5000, 16'h0000);
    #1;
    check_eq("ldi.p_read", 32'(u_if.mem_read), 32'h1);
    check_eq("ldi.p_addr", 32'(u_if.mem_address), 32'h5000);
    check_eq("ldi.p_be", 32'(u_if.mem_byte_enable), 32'h3);
    next_cycle();
    resp(1'b1, 16'h6003);
    #1;
    check_eq("ldi.p_done", 32'(u_if.done), 32'h0);
    check_eq("ldi.p_stall", 32'(u_if.stall), 32'h1);
    next_cycle();
    resp(1'b0, 16'h0000);
    #1;
    check_eq("ldi.d_addr", 32'(u_if.mem_address), 32'h6002);
    check_eq("ldi.d_read", 32'(u_if.mem_read), 32'h1);
    check_eq("ldi.d_be", 32'(u_if.mem_byte_enable), 32'h3);
    check_eq("ldi.d_stall", 32'(u_if.stall), 32'h1);
    next_cycle();
    resp(1'b1, 16'h0042);
    #1;
    check_eq("ldi.done", 32'(u_if.done), 32'h1);
    check_eq("ldi.rdata", 32'(u_if.rdata), 32'h0042);

    // STI: pointer 0x7000, store 0x1234
    next_cycle();
    resp(1'b0, 16'h0000);
    drive(1'b1, cw(op_sti, 1'b0, 1'b0), 16'h5100, 16'h1234);
    #1;
    check_eq("sti.p_read", 32'(u_if.mem_read), 32'h1);
    check_eq("sti.p_write", 32'(u_if.mem_write), 32'h0);
    check_eq("sti.p_addr", 32'(u_if.mem_address), 32'h5100);
    next_cycle();
    resp(1'b1, 16'h7000);
    #1;
    check_eq("sti.p_done", 32'(u_if.done), 32'h0);
    next_cycle();
    resp(1'b0, 16'h0000);
    #1;
    check_eq("sti.d_write", 32'(u_if.mem_write), 32'h1);
    check_eq("sti.d_read", 32'(u_if.mem_read), 32'h0);
    check_eq("sti.d_addr", 32'(u_if.mem_address), 32'h7000);
    check_eq("sti.d_wdata", 32'(u_if.mem_wdata), 32'h1234);
    check_eq("sti.d_be", 32'(u_if.mem_byte_enable), 32'h3);
    next_cycle();
    resp(1'b1, 16'h0000);
    #1;
    check_eq("sti.done", 32'(u_if.done), 32'h1);
    check_eq("sti.read_resp", 32'(u_if.mem_read), 32'h0);

    // ADD then LDB at odd address
    next_cycle();
    resp(1'b0, 16'h0000);
    drive(1'b1, cw(op_add, 1'b0, 1'b0), 16'h2001, 16'h0000);
    #1;
    check_eq("add.done", 32'(u_if.done), 32'h1);
    check_eq("add.stall", 32'(u_if.stall), 32'h0);
    check_eq("add.read", 32'(u_if.mem_read), 32'h0);
    check_eq("add.write", 32'(u_if.mem_write), 32'h0);
    next_cycle();
    drive(1'b1, cw(op_ldb, 1'b1, 1'b0), 16'h2001, 16'h0000);
    #1;
    check_eq("ldb.addr", 32'(u_if.mem_address), 32'h2001);
    check_eq("ldb.be", 32'(u_if.mem_byte_enable), 32'h2);
    check_eq("ldb.stall", 32'(u_if.stall), 32'h1);
    next_cycle();
    resp(1'b1, 16'h80FF);
    #1;
    check_eq("ldb.done", 32'(u_if.done), 32'h1);
    check_eq("ldb.rdata", 32'(u_if.rdata), 32'h0080);

    // Stray response with nothing in flight
    next_cycle();
    drive(1'b0, cw(op_br, 1'b0, 1'b0), 16'h0000, 16'h0000);
    resp(1'b1, 16'hFFFF);
    #1;
    check_eq("stray.done", 32'(u_if.done), 32'h0);
    check_eq("stray.read", 32'(u_if.mem_read), 32'h0);

    // Reset while in INDIRECT
    next_cycle();
    resp(1'b0, 16'h0000);
    drive(1'b1, cw(op_ldi, 1'b1, 1'b0), 16'h5000, 16'h0000);
    next_cycle();
    resp(1'b1, 16'h6003);
    next_cycle();
    resp(1'b0, 16'h0000);
    #1;
    check_eq("rst.pre_addr", 32'(u_if.mem_address), 32'h6002);
    #2;
    rst_n = 1'b0;
    u_if.in_valid = 1'b0;
    #1;
    check_all_zero("rst");
    next_cycle();
    rst_n = 1'b1;
    resp(1'b1, 16'h1111);
    #1;
    check_eq("rst.stray_done", 32'(u_if.done), 32'h0);
    next_cycle();
    resp(1'b0, 16'h0000);
    drive(1'b1, cw(op_ldi, 1'b1, 1'b0), 16'h5000, 16'h0000);
    #1;
    check_eq("rst.idle_addr", 32'(u_if.mem_address), 32'h5000);
    next_cycle();
    resp(1'b1, 16'h6003);
    #1;
    check_eq("rst.p_done", 32'(u_if.done), 32'h0);
    next_cycle();
    resp(1'b0, 16'h0000);
    #1;
    check_eq("rst.d_addr", 32'(u_if.mem_address), 32'h6002);
    next_cycle();
    resp(1'b1, 16'h0042);
    #1;
    check_eq("rst.done", 32'(u_if.done), 32'h1);
    check_eq("rst.rdata", 32'(u_if.rdata), 32'h0042);
    next_cycle();
    resp(1'b0, 16'h0000);
    drive(1'b0, cw(op_br, 1'b0, 1'b0), 16'h0000, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
